// File: rtl/waffle_pkg.sv
// Shared constants and types for the memory/IO responder: I/O register
// addresses, IRQ_STAT bit positions and the byte type.
package waffle_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [15:0] ADDR_IRQ_STAT   = 16'd996;
  localparam logic [15:0] ADDR_TMR_RELOAD = 16'd997;
  localparam logic [15:0] ADDR_SW         = 16'd998;
  localparam logic [15:0] ADDR_LED        = 16'd999;

  localparam int IRQ_TMR = 0;
  localparam int IRQ_SW  = 1;

endpackage

// File: rtl/tick_timer.sv
// Prescaled down-counting timer. Writing the reload value also loads the
// count and restarts the prescaler. A reload of zero parks the timer with no
// ticks. expire_o pulses on the tick where the count reaches terminal count
// (1), and the count is reloaded on that same cycle.
module tick_timer
  import waffle_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  byte_t load_val_i,
  output byte_t count_o,
  output logic  expire_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pscl_q, pscl_d;
  byte_t         reload_q, reload_d;
  byte_t         count_q, count_d;
  logic          tick;

  // Next-state: a load wins over a coincident tick, so a rewrite always
  // starts a fresh period.
  always_comb begin
    pscl_d   = pscl_q;
    reload_d = reload_q;
    count_d  = count_q;
    expire_o = 1'b0;
    tick     = (reload_q != 8'h00) && (pscl_q == PS_MAX);
    if (load_i) begin
      reload_d = load_val_i;
      count_d  = load_val_i;
      pscl_d   = '0;
    end else if (reload_q != 8'h00) begin
      if (tick) begin
        pscl_d = '0;
        if (count_q > 8'd1) begin
          count_d = count_q - 8'd1;
        end else if (count_q == 8'd1) begin
          expire_o = 1'b1;
          count_d  = reload_q;
        end
      end else begin
        pscl_d = pscl_q + 1'b1;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pscl_q   <= '0;
      reload_q <= 8'h00;
      count_q  <= 8'h00;
    end else begin
      pscl_q   <= pscl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU-side memory and I/O responder: byte RAM at 0..RAM_DEPTH-1 plus
// IRQ_STAT (996), timer reload/count (997), switches (998) and LEDs (999).
// Read data is registered (one cycle latency, read-first on RAM).
// Build option: define SW_IRQ_EN to raise IRQ_STAT bit1 on any change of the
// synchronized switch value; otherwise bit1 is tied to 0.
module mem_io_responder
  import waffle_pkg::*;
#(
  parameter int RAM_DEPTH = 900,
  parameter int PRESCALE  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  sw_in,
  output logic [7:0]  ledr,
  output logic [7:0]  irq
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [15:0] RAM_LIMIT = 16'(RAM_DEPTH);

  byte_t         mem [RAM_DEPTH];
  logic [AW-1:0] ram_idx;
  logic          is_ram, wr_ram, wr_irq, wr_tmr, wr_led;
  byte_t         dout_q, dout_d;
  byte_t         led_q, led_d;
  byte_t         irq_q, irq_d, irq_set, irq_clr;
  byte_t         sw_meta_q, sw_sync_q;
  byte_t         tmr_count;
  logic          tmr_expire;
  logic          sw_evt;

  assign ram_idx = addr[AW-1:0];

  // Address decode, read mux and next-state for LED / IRQ_STAT.
  always_comb begin
    is_ram = (addr < RAM_LIMIT);
    wr_ram = we && is_ram;
    wr_irq = we && !is_ram && (addr == ADDR_IRQ_STAT);
    wr_tmr = we && !is_ram && (addr == ADDR_TMR_RELOAD);
    wr_led = we && !is_ram && (addr == ADDR_LED);

    dout_d = 8'h00;
    if (is_ram) begin
      dout_d = mem[ram_idx];
    end else begin
      case (addr)
        ADDR_IRQ_STAT:   dout_d = irq_q;
        ADDR_TMR_RELOAD: dout_d = tmr_count;
        ADDR_SW:         dout_d = sw_sync_q;
        ADDR_LED:        dout_d = led_q;
        default:         dout_d = 8'h00;
      endcase
    end

    led_d = wr_led ? din : led_q;

    irq_set          = 8'h00;
    irq_set[IRQ_TMR] = tmr_expire;
    irq_set[IRQ_SW]  = sw_evt;
    irq_clr          = wr_irq ? din : 8'h00;
    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    irq_d            = ((irq_q & ~irq_clr) | irq_set) & 8'h03;
  end

  // RAM array: not reset, and writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (wr_ram && !rst) mem[ram_idx] <= din;
  end

  // Read data, LED, IRQ_STAT and switch synchronizer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= 8'h00;
      led_q     <= 8'h00;
      irq_q     <= 8'h00;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      dout_q    <= dout_d;
      led_q     <= led_d;
      irq_q     <= irq_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef SW_IRQ_EN
  byte_t sw_prev_q;

  // Previous synchronized switch value for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_prev_q <= 8'h00;
    else     sw_prev_q <= sw_sync_q;
  end

  assign sw_evt = (sw_sync_q != sw_prev_q);
`else
  assign sw_evt = 1'b0;
`endif

  tick_timer #(
    .PRESCALE (PRESCALE)
  ) u_tick_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wr_tmr),
    .load_val_i (din),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  assign dout = dout_q;
  assign ledr = led_q;
  assign irq  = irq_q;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 900: number of RAM bytes, mapped at addresses 0..RAM_DEPTH-1.
REQ-002 SHALL have parameter PRESCALE, default 50000: clk cycles per timer tick.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port addr, input, 16 bits: CPU bus address.
REQ-006 SHALL have port we, input, 1 bit: write strobe, sampled each cycle.
REQ-007 SHALL have port din, input, 8 bits: write data.
REQ-008 SHALL have port dout, output, 8 bits: registered read data.
REQ-009 SHALL have port sw_in, input, 8 bits: asynchronous board switches.
REQ-010 SHALL have port ledr, output, 8 bits: LED register.
REQ-011 SHALL have port irq, output, 8 bits: interrupt request vector to the CPU; nonzero means interrupt.

Function
REQ-012 SHALL decode the address map: 0..RAM_DEPTH-1 RAM; 996 IRQ_STAT; 997 TMR_RELOAD; 998 SW; 999 LED; all other addresses unmapped.
REQ-013 SHALL register dout every cycle from the address presented that cycle, giving 1-cycle read latency.
REQ-014 SHALL return read-first (old) data on a RAM read and write to the same address in the same cycle.
REQ-015 SHALL return 0x00 on dout for unmapped addresses, and SHALL ignore writes to them.
REQ-016 SHALL set ledr to din on a write to 999; a read of 999 returns ledr.
REQ-017 SHALL pass sw_in through a two-flop synchronizer; a read of 998 returns the synchronized value; writes to 998 are ignored.
REQ-018 SHALL load a write to 997 into the reload register and count register, and clear the prescaler; a read of 997 returns the current count.
REQ-019 SHALL hold the timer idle with no ticks while reload is 0x00.
REQ-020 SHALL, with reload nonzero, pulse a tick when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
REQ-021 SHALL, on each tick, decrement count if count > 1; if count == 1, set IRQ_STAT bit0 and reload count from reload.
REQ-022 SHALL make IRQ_STAT bits sticky; a write to 996 clears each bit where din is 1 (write-1-to-clear).
REQ-023 SHALL give set priority over clear when a set and a write-1-to-clear hit the same bit in the same cycle.
REQ-024 SHALL drive irq = IRQ_STAT, with bits 7:2 always 0; a read of 996 returns IRQ_STAT.

Reset
REQ-025 SHALL on rst clear dout, ledr, IRQ_STAT, reload, count, prescaler and synchronizer/edge flops to 0, immediately and independent of clk.
REQ-026 SHALL NOT reset RAM contents; a write coincident with rst SHALL NOT take effect in registers.
REQ-027 SHALL restart the timer from idle when rst is asserted mid-count; no stale tick or IRQ may follow.

Configuration
REQ-028 SHALL, with macro SW_IRQ_EN defined, set IRQ_STAT bit1 one cycle after the synchronized switch value differs from its previous synchronized value.
REQ-029 SHALL, without SW_IRQ_EN, omit edge-detect logic and hold IRQ_STAT bit1 at 0 for both reads and irq.

Structure
REQ-030 SHALL place the address constants (996..999), IRQ bit indices (TMR=0, SW=1) and byte typedef in shared package waffle_pkg.
REQ-031 SHALL implement prescaler, count and reload in sub-module tick_timer; RAM, decode, LED, switch and IRQ logic stay in mem_io_responder.

Verification
REQ-032 SHALL cover: write 0x5A to addr 10, then read addr 10 -> dout 0x5A one cycle later; read addr 950 -> 0x00.
REQ-033 SHALL cover: write 0xC3 to 999 -> ledr 0xC3 next cycle; sw_in=0x81 held 3 cycles, read 998 -> 0x81.
REQ-034 SHALL cover, with PRESCALE=4: write 0x03 to 997 -> irq bit0 set after 12 cycles; write 0x01 to 996 -> cleared; count reloads to 3.
REQ-035 SHALL cover: clear and timer set in the same cycle -> bit0 remains 1.
REQ-036 SHALL cover, with SW_IRQ_EN defined: toggle sw_in bit4 -> irq=0x02 within 3 cycles; without the macro, irq stays 0x00.
REQ-037 SHALL cover: assert rst mid-count -> irq, ledr, dout and count 0 immediately; no tick after release until 997 is rewritten.
